// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: a - b - borrow_in, one bit per clock, LSB first.
// Optional signed overflow output enabled by defining SERIAL_SUB_SIGNED_OVF_EN.
module serial_subtractor_nbit #(
  parameter int unsigned NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                underflow
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  ,
  output logic                signed_ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state;
  logic [NUM_BITS-1:0] a_sr;
  logic [NUM_BITS-1:0] b_sr;
  logic [NUM_BITS-1:0] res_sr;
  logic                br;
  logic [CNT_W-1:0]    cnt;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic                a_msb;
  logic                b_msb;
`endif

  // One full-subtractor cell operating on the current operand LSBs
  logic                ai_c;
  logic                bi_c;
  logic                d_c;
  logic                br_next_c;
  logic [NUM_BITS-1:0] res_next_c;

  assign ai_c       = a_sr[0];
  assign bi_c       = b_sr[0];
  assign d_c        = ai_c ^ bi_c ^ br;
  assign br_next_c  = (~ai_c & bi_c) | (~(ai_c ^ bi_c) & br);
  assign res_next_c = {d_c, res_sr[NUM_BITS-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      underflow <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      signed_ovf <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // DONE accepts start like IDLE so operations can run back to back
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= borrow_in;
            res_sr <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb <= a[NUM_BITS-1];
            b_msb <= b[NUM_BITS-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= br_next_c;
          res_sr <= res_next_c;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            diff      <= res_next_c;
            underflow <= br_next_c;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            signed_ovf <= (a_msb != b_msb) && (d_c != a_msb);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Scoreboard bench for serial_subtractor_nbit (NUM_BITS=4); build with
// SERIAL_SUB_SIGNED_OVF_EN defined to also check signed_ovf.
module tb_serial_subtractor_nbit;

  typedef struct packed {
    logic [3:0] d;
    logic       uf;
    logic       ovf;
  } exp_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    exp_t       e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       borrow_in;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       underflow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic       signed_ovf;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t exp_q[$];
  int done_cyc[$];

  serial_subtractor_nbit #(.NUM_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .underflow (underflow)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    .signed_ovf(signed_ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, want);
    end
  endtask

  // Monitor: pop the oldest expectation whenever the DUT presents a result
  always @(negedge clk) begin
    if (done) begin
      done_cyc.push_back(cyc);
      chk("busy_done_overlap", 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got diff=%0h uf=%0b exp none", diff, underflow);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_diff_uf", {27'd0, diff, underflow}, {27'd0, e.d, e.uf});
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("result_signed_ovf", 32'(signed_ovf), 32'(e.ovf));
`endif
      end
    end
  end

  function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv, input logic bi);
    exp_t e;
    int t;
    t = int'(av) - int'(bv) - int'(bi);
    e.d = 4'(t);
    e.uf = (t < 0);
    e.ovf = (av[3] != bv[3]) && (e.d[3] != av[3]);
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] av, input logic [3:0] bv, input logic bi,
                              input logic [3:0] d, input logic uf, input logic ovf);
    vec_t v;
    v.a = av; v.b = bv; v.bin = bi;
    v.e.d = d; v.e.uf = uf; v.e.ovf = ovf;
    return v;
  endfunction

  // Single operation with latency and busy-length checks
  task automatic run_op(input vec_t v);
    int lat;
    int busy_n;
    @(negedge clk);
    a = v.a; b = v.b; borrow_in = v.bin; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(v.e);
    #1 start = 1'b0;
    lat = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
    end while (!done && lat < 20);
    chk("latency", 32'(lat), 32'd5);
    chk("busy_cycles", 32'(busy_n), 32'd4);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Start held high; operands change right after each acceptance
  task automatic run_b2b(input vec_t vq[$]);
    int n0;
    n0 = done_cyc.size();
    @(negedge clk);
    a = vq[0].a; b = vq[0].b; borrow_in = vq[0].bin; start = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      exp_q.push_back(vq[i].e);
      #1;
      if (i + 1 < vq.size()) begin
        a = vq[i+1].a; b = vq[i+1].b; borrow_in = vq[i+1].bin;
      end else begin
        start = 1'b0;
      end
      repeat (4) @(posedge clk);
    end
    drain();
    chk("b2b_done_count", 32'(done_cyc.size() - n0), 32'(vq.size()));
    for (int k = n0 + 1; k < done_cyc.size(); k++)
      chk("b2b_gap", 32'(done_cyc[k] - done_cyc[k-1]), 32'd5);
  endtask

  initial begin
    vec_t dq[$];
    vec_t sq[$];
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_uf", 32'(underflow), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk("rst_ovf", 32'(signed_ovf), 32'd0);
`endif
    rst = 1'b0;

    run_op(mk(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1));
    run_op(mk(4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b1));
    run_op(mk(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0));
    drain();

    // start during SHIFT must be ignored: result stays 12-5, no extra done
    @(negedge clk);
    a = 4'd12; b = 4'd5; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    exp_q.push_back(mk(4'd12, 4'd5, 1'b0, 4'd7, 1'b0, 1'b1).e);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 4'd5; b = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);
    chk("ignored_start_busy", 32'(busy), 32'd0);

    // Reset in the second busy cycle aborts; start alongside rst is ignored
    @(negedge clk);
    a = 4'd9; b = 4'd3; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_uf", 32'(underflow), 32'd0);
    n = done_cyc.size();
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(done_cyc.size() - n), 32'd0);
    run_op(mk(4'd7, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0));
    drain();

    dq.push_back(mk(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1));
    dq.push_back(mk(4'd3, 4'd9, 1'b0, 4'd10, 1'b1, 1'b1));
    dq.push_back(mk(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0));
    dq.push_back(mk(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1));
    dq.push_back(mk(4'd7, 4'd1, 1'b0, 4'd6, 1'b0, 1'b0));
    dq.push_back(mk(4'd7, 4'd15, 1'b0, 4'd8, 1'b1, 1'b1));
    run_b2b(dq);

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          vec_t v;
          v.a = 4'(ai); v.b = 4'(bi); v.bin = 1'(ci);
          v.e = model(v.a, v.b, v.bin);
          sq.push_back(v);
        end
    run_b2b(sq);

    repeat (5) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_nbit.md
# serial_subtractor_nbit

Bit-serial N-bit subtractor computing `a - b - borrow_in` one bit per clock, LSB first. It is the subtraction counterpart of the team's combinational N-bit adder and trades latency for area. Used in datapaths that can tolerate NUM_BITS+1 cycles of latency. A start/busy/done handshake lets a controller launch an operation and collect a held result.

## Interface
- NUM_BITS, 4, operand and result width; legal range ≥ 2.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  NUM_BITS  minuend; captured on accepted start.
- b  input  NUM_BITS  subtrahend; captured on accepted start.
- borrow_in  input  1  borrow into bit 0; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  NUM_BITS  result register; held between operations.
- underflow  output  1  final borrow out (unsigned a < b + borrow_in).
- signed_ovf  output  1  two's-complement overflow; present only under the macro.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - start=1 captures a, b and borrow_in into the operand shift registers and the borrow flop, clears the bit counter, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, once per cycle on the current LSBs ai, bi and borrow br:
  - d = ai ^ bi ^ br.
  - br' = (~ai & bi) | (~(ai ^ bi) & br).
  - d shifts into the MSB of the internal result shift register.
  - The operands shift right.
  - The counter increments. After the NUM_BITS-th bit the FSM goes to DONE.
- Entering DONE:
  - The internal result copies to diff.
  - The final borrow copies to underflow.
  - signed_ovf updates when compiled in.
- DONE lasts exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation into SHIFT.
  - Otherwise the FSM returns to IDLE.
- start while in SHIFT is ignored. It is neither queued nor a restart.
- diff and underflow change only on entry to DONE or on reset. They never show partial results.
- Operand inputs need to be stable only in the cycle start is accepted.
- Arithmetic is modulo 2^NUM_BITS.
  - Example: a=0, b=0, borrow_in=1 gives diff = all ones and underflow=1.

## Timing
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, diff=0, underflow=0, signed_ovf=0.
  - Internal registers and counter are cleared.
- start accepted at edge T:
  - busy=1 for exactly NUM_BITS cycles, from after T through edge T+NUM_BITS.
  - done=1 and the new diff/underflow are visible in the cycle after edge T+NUM_BITS.
  - Total latency from accepted start to done is NUM_BITS+1 cycles.
- busy and done are never high together.
- Back-to-back: start held high gives one done every NUM_BITS+1 cycles.
- rst asserted mid-SHIFT aborts the operation:
  - Everything returns to reset values on that edge.
  - No done is produced.
  - A start seen in the same cycle as rst is ignored.
- The counter is ceil(log2(NUM_BITS+1)) bits wide and must not wrap before NUM_BITS.

## Configuration
- SERIAL_SUB_SIGNED_OVF_EN defined:
  - The signed_ovf port exists.
  - On DONE entry it registers (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs.
  - It is held like diff and cleared by reset.
- SERIAL_SUB_SIGNED_OVF_EN undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use NUM_BITS=4.
- Reset: hold rst for 2 cycles, then check busy=0, done=0, diff=0, underflow=0 (signed_ovf=0 when compiled in).
- a=9, b=3, borrow_in=0, start for one cycle:
  - busy is high for 4 cycles.
  - done pulses on cycle 5.
  - Result diff=6, underflow=0.
- Underflow cases:
  - a=3, b=9, borrow_in=0 gives diff=10, underflow=1.
  - a=0, b=0, borrow_in=1 gives diff=15, underflow=1.
- Protocol:
  - Pulse start with a=5, b=2 during SHIFT and check it is ignored.
  - Assert rst in the second busy cycle: no done, outputs are 0, and the next start with a=7, b=7 gives diff=0, underflow=0.
- Back-to-back and exhaustive:
  - Hold start high: results are done every 5 cycles.
  - Sweep all 512 (a, b, borrow_in) combinations and compare against (a - b - borrow_in) mod 16 and the borrow.
- Macro defined:
  - a=8, b=1 gives diff=7, signed_ovf=1.
  - a=7, b=1 gives diff=6, signed_ovf=0.
  - a=7, b=15 gives diff=8, signed_ovf=1.
